// File: rtl/a7link_pkg.sv
// rtl/a7link_pkg.sv - shared constants, state type and frame builder for the a7link sequencer
package a7link_pkg;

    localparam logic [7:0] OP_RD          = 8'h01;
    localparam logic [7:0] OP_WR          = 8'h02;
    localparam int         FRAME_BITS     = 12;
    localparam int         FRAMES_PER_REQ = 5;
    localparam int         STREAM_BITS    = FRAME_BITS * FRAMES_PER_REQ;
    localparam logic [7:0] TIMEOUT_STATUS = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Frame layout, MSB first on the wire: start(1), flag, data[7:0], 0, 0
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic flag, input logic [7:0] data);
        return {1'b1, flag, data, 2'b00};
    endfunction

endpackage

// File: rtl/a7link.sv
// rtl/a7link.sv - single-bit pass-through helper; the sequencer top is a7link_seq
module a7link_unused_stub (
    input  logic a_i,
    output logic a_o
);
    assign a_o = a_i;
endmodule

// File: rtl/a7link_deframer.sv
// rtl/a7link_deframer.sv - serial receive deframer for the a7link far-end line
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   serial_i   raw serial line from the far end
//   stb_o      one-cycle pulse: a frame was detected
//   data_o     data byte of the detected frame (valid with stb_o, held after)
//   flag_o     flag bit of the detected frame (valid with stb_o, held after)
module a7link_deframer
    import a7link_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       serial_i,
    output logic       stb_o,
    output logic [7:0] data_o,
    output logic       flag_o
);

    logic                  sin_q;
    logic [FRAME_BITS-1:0] shreg_q;
    logic [FRAME_BITS-1:0] shreg_d;
    logic                  hit;
    logic                  stb_q;
    logic [7:0]            data_q;
    logic                  flag_q;

    // Detection looks at the value about to be shifted in, so the clear
    // happens on the same edge and the next frame's start bit (arriving on
    // the following edge) lands in a clean register.
    always_comb begin
        shreg_d = {shreg_q[FRAME_BITS-2:0], sin_q};
        hit     = shreg_d[FRAME_BITS-1] && (shreg_d[1:0] == 2'b00);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sin_q   <= 1'b0;
            shreg_q <= '0;
            stb_q   <= 1'b0;
            data_q  <= 8'h00;
            flag_q  <= 1'b0;
        end else begin
            sin_q <= serial_i;
            stb_q <= hit;
            if (hit) begin
                data_q  <= shreg_d[9:2];
                flag_q  <= shreg_d[10];
                shreg_q <= '0;
            end else begin
                shreg_q <= shreg_d;
            end
        end
    end

    assign stb_o  = stb_q;
    assign data_o = data_q;
    assign flag_o = flag_q;

endmodule

// File: rtl/a7link_seq.sv
// rtl/a7link_seq.sv - register-access sequencer: frames a request, awaits the reply, reports completion
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_wr, req_addr, req_wrdata  request contents, captured on acceptance
//   rsp_valid                     one-cycle completion pulse
//   rsp_timeout/status/rddata     completion result, held until the next completion
//   serial_out, serial_in         serial lines to / from the far end
//   busy                          state is not IDLE
//   cnt_sent/rcvd/timeout         wrapping frame and timeout counters
module a7link_seq
    import a7link_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [15:0]      req_addr,
    input  logic [15:0]      req_wrdata,
    output logic             rsp_valid,
    output logic             rsp_timeout,
    output logic [7:0]       rsp_status,
    output logic [15:0]      rsp_rddata,
    output logic             serial_out,
    input  logic             serial_in,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_sent,
    output logic [CNT_W-1:0] cnt_rcvd,
    output logic [CNT_W-1:0] cnt_timeout
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t                 state_q;
    logic [STREAM_BITS-1:0] tx_shift_q;
    logic [STREAM_BITS-1:0] stream_d;
    logic [3:0]             frame_bit_q;
    logic [2:0]             frame_idx_q;
    logic                   serial_out_q;
    logic [TMO_W-1:0]       tmo_cnt_q;
    logic [15:0]            resp_q;
    logic                   rsp_valid_q;
    logic                   rsp_timeout_q;
    logic [7:0]             rsp_status_q;
    logic [15:0]            rsp_rddata_q;
    logic [CNT_W-1:0]       cnt_sent_q;
    logic [CNT_W-1:0]       cnt_rcvd_q;
    logic [CNT_W-1:0]       cnt_timeout_q;
    logic [15:0]            wd;
    logic [7:0]             op;
    logic                   rx_stb;
    logic [7:0]             rx_data;
    logic                   rx_flag;

    a7link_deframer u_deframer (
        .clk_i    (clk),
        .rst_i    (rst),
        .serial_i (serial_in),
        .stb_o    (rx_stb),
        .data_o   (rx_data),
        .flag_o   (rx_flag)
    );

    // Whole 60-bit request stream, built from the live request inputs and
    // loaded into the transmit shifter on the acceptance edge.
    always_comb begin
        wd       = req_wr ? req_wrdata : 16'h0000;
        op       = req_wr ? OP_WR : OP_RD;
        stream_d = {make_frame(1'b0, op),
                    make_frame(1'b0, req_addr[15:8]),
                    make_frame(1'b0, req_addr[7:0]),
                    make_frame(1'b0, wd[15:8]),
                    make_frame(1'b1, wd[7:0])};
    end

    // resp_q holds the two most recent reply bytes; together with the byte
    // arriving in the flagged frame it forms the 24-bit response window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            tx_shift_q    <= '0;
            frame_bit_q   <= 4'd0;
            frame_idx_q   <= 3'd0;
            serial_out_q  <= 1'b0;
            tmo_cnt_q     <= '0;
            resp_q        <= 16'h0000;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_status_q  <= 8'h00;
            rsp_rddata_q  <= 16'h0000;
            cnt_sent_q    <= '0;
            cnt_rcvd_q    <= '0;
            cnt_timeout_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (rx_stb) begin
                cnt_rcvd_q <= cnt_rcvd_q + CNT_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        state_q      <= ST_SEND;
                        serial_out_q <= stream_d[STREAM_BITS-1];
                        tx_shift_q   <= {stream_d[STREAM_BITS-2:0], 1'b0};
                        frame_bit_q  <= 4'd1;
                        frame_idx_q  <= 3'd0;
                        cnt_sent_q   <= cnt_sent_q + CNT_W'(1);
                    end
                end
                ST_SEND: begin
                    if (frame_bit_q == 4'(FRAME_BITS)) begin
                        if (frame_idx_q == 3'(FRAMES_PER_REQ - 1)) begin
                            state_q      <= ST_WAIT;
                            serial_out_q <= 1'b0;
                            resp_q       <= 16'h0000;
                            tmo_cnt_q    <= '0;
                        end else begin
                            frame_idx_q  <= frame_idx_q + 3'd1;
                            frame_bit_q  <= 4'd1;
                            cnt_sent_q   <= cnt_sent_q + CNT_W'(1);
                            serial_out_q <= tx_shift_q[STREAM_BITS-1];
                            tx_shift_q   <= {tx_shift_q[STREAM_BITS-2:0], 1'b0};
                        end
                    end else begin
                        frame_bit_q  <= frame_bit_q + 4'd1;
                        serial_out_q <= tx_shift_q[STREAM_BITS-1];
                        tx_shift_q   <= {tx_shift_q[STREAM_BITS-2:0], 1'b0};
                    end
                end
                ST_WAIT: begin
                    // A flagged frame wins over a timeout landing on the same cycle.
                    if (rx_stb && rx_flag) begin
                        state_q       <= ST_DONE;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b0;
                        rsp_status_q  <= rx_data;
                        rsp_rddata_q  <= resp_q;
                    end else begin
                        if (rx_stb) begin
                            resp_q <= {resp_q[7:0], rx_data};
                        end
                        if (tmo_cnt_q == TMO_LAST) begin
                            state_q       <= ST_DONE;
                            rsp_valid_q   <= 1'b1;
                            rsp_timeout_q <= 1'b1;
                            rsp_status_q  <= TIMEOUT_STATUS;
                            rsp_rddata_q  <= 16'h0000;
                            cnt_timeout_q <= cnt_timeout_q + CNT_W'(1);
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign serial_out  = serial_out_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_status  = rsp_status_q;
    assign rsp_rddata  = rsp_rddata_q;
    assign cnt_sent    = cnt_sent_q;
    assign cnt_rcvd    = cnt_rcvd_q;
    assign cnt_timeout = cnt_timeout_q;

endmodule
